// File: rtl/eth_status_pkg.sv
// Shared LED status encoding and counter-width helper for the link status block.
// Latency: none (declarations only).
// Backpressure: none.
package eth_status_pkg;

  typedef enum logic [1:0] {
    LED_OFF          = 2'd0,
    LED_GREEN        = 2'd1,
    LED_YELLOW_SOLID = 2'd2,
    LED_YELLOW_BLINK = 2'd3
  } led_state_t;

  // Bits needed to hold max_value; never less than 1 so counters stay legal.
  function automatic int cnt_width(input int max_value);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) <= max_value)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/eth_link_debounce.sv
// Per-lane lock synchroniser, debounce to link_up and saturating flap counter.
// Latency: link_up follows a stable lock change 2 + DEBOUNCE_CYCLES cycles later.
// Backpressure: none; status path, always accepts input.
module eth_link_debounce
  import eth_status_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int FLAP_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock_raw,
  input  logic              flap_clear,
  output logic              link_up,
  output logic              toggle,
  output logic [FLAP_W-1:0] flap_count
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_s;
  logic [CW-1:0] cnt;
  logic          going_down;

  // toggle is the "link_up changes on this edge" condition; the top registers it.
  assign toggle     = (sync_s != link_up) && (cnt == CNT_LAST);
  assign going_down = toggle && link_up;

  // Two-flop synchroniser: lock is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
    end else begin
      sync_meta <= lock_raw;
      sync_s    <= sync_meta;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      link_up <= 1'b0;
    end else if (sync_s == link_up) begin
      cnt <= '0;
    end else if (toggle) begin
      cnt     <= '0;
      link_up <= ~link_up;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Down transitions saturate; a clear that lands on a drop still records that drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flap_count <= '0;
    end else if (flap_clear) begin
      flap_count <= going_down ? FLAP_W'(1) : '0;
    end else if (going_down && (flap_count != {FLAP_W{1'b1}})) begin
      flap_count <= flap_count + FLAP_W'(1);
    end
  end

endmodule

// File: rtl/eth_link_status_led.sv
// Multi-lane link status: debounced link_up, flap counts, QSFP activity/status LEDs.
// Latency: link_up 2+DEBOUNCE_CYCLES after lock change; LEDs one cycle after their inputs.
// Backpressure: none; status path, always accepts input.
module eth_link_status_led
  import eth_status_pkg::*;
#(
  parameter int CH_COUNT           = 4,
  parameter int DEBOUNCE_CYCLES    = 1024,
  parameter int ACT_STRETCH_CYCLES = 4096,
  parameter int BLINK_PERIOD       = 16384,
  parameter int FLAP_W             = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CH_COUNT-1:0]        rx_block_lock,
  input  logic [CH_COUNT-1:0]        activity,
  input  logic [CH_COUNT-1:0]        ch_enable,
  input  logic                       flap_clear,
  output logic [CH_COUNT-1:0]        link_up,
  output logic                       link_change,
  output logic [CH_COUNT*FLAP_W-1:0] flap_count,
  output logic                       led_act,
  output logic                       led_stat_g,
  output logic                       led_stat_y
);

  localparam int            SW         = cnt_width(ACT_STRETCH_CYCLES);
  localparam int            BW         = cnt_width(BLINK_PERIOD - 1);
  localparam logic [SW-1:0] STRETCH_LD = SW'(ACT_STRETCH_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_HALF = BW'(BLINK_PERIOD / 2);

  logic [CH_COUNT-1:0] toggle;
  logic [SW-1:0]       stretch_cnt;
  logic [SW-1:0]       stretch_next;
  logic [BW-1:0]       blink_cnt;
  logic                phase;
  logic [CH_COUNT-1:0] up_enabled;
  led_state_t          state_next;

  for (genvar i = 0; i < CH_COUNT; i++) begin : g_lane
    eth_link_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .FLAP_W         (FLAP_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .lock_raw  (rx_block_lock[i]),
      .flap_clear(flap_clear),
      .link_up   (link_up[i]),
      .toggle    (toggle[i]),
      .flap_count(flap_count[i*FLAP_W +: FLAP_W])
    );
  end

  // Pulse whenever any lane's link_up flips on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) link_change <= 1'b0;
    else     link_change <= |toggle;
  end

  // Retriggerable stretch: any qualified pulse reloads, otherwise count down to zero.
  always_comb begin
    stretch_next = stretch_cnt;
    if (|(activity & link_up & ch_enable)) stretch_next = STRETCH_LD;
    else if (stretch_cnt != '0)            stretch_next = stretch_cnt - SW'(1);
  end

  // Stretch counter and activity LED, both registered from the same next value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stretch_cnt <= '0;
      led_act     <= 1'b0;
    end else begin
      stretch_cnt <= stretch_next;
      led_act     <= (stretch_next != '0);
    end
  end

  // Free-running blink timebase; first half of the period is the "on" phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          blink_cnt <= '0;
    else if (blink_cnt == BLINK_LAST) blink_cnt <= '0;
    else                              blink_cnt <= blink_cnt + BW'(1);
  end

  assign phase      = (blink_cnt < BLINK_HALF);
  assign up_enabled = link_up & ch_enable;

  // Classify the enabled lanes into one of the four LED states.
  always_comb begin
    state_next = LED_OFF;
    if (ch_enable == '0)               state_next = LED_OFF;
    else if (up_enabled == ch_enable)  state_next = LED_GREEN;
    else if (up_enabled == '0)         state_next = LED_YELLOW_SOLID;
    else                               state_next = LED_YELLOW_BLINK;
  end

  // Registered status LEDs driven from the classified state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_stat_g <= 1'b0;
      led_stat_y <= 1'b0;
    end else begin
      led_stat_g <= (state_next == LED_GREEN);
      led_stat_y <= (state_next == LED_YELLOW_SOLID) ||
                    ((state_next == LED_YELLOW_BLINK) && phase);
    end
  end

endmodule
